// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that lets NREQ requesters take turns writing bursts of up
// to BURST beats into a single FIFO, stalling on full and counting stall cycles.
module fifo_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] d_req,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       gnt,
  output logic                  wren,
  output logic [WIDTH-1:0]      d_in,
  input  logic                  fifo_full,
  output logic [15:0]           stall_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
  localparam logic [IW:0]   NREQ_W   = (IW + 1)'(NREQ);
  localparam logic [CW-1:0] CNT_MAX  = CW'(BURST - 1);

  logic [0:0]      state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   lsp_q,   lsp_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [NREQ-1:0] gnt_q,   gnt_d;
  logic [15:0]     stall_q, stall_d;

  logic            found;
  logic [IW-1:0]   pick;

  // Scan lsp+1, lsp+2, ... wrapping, so the last-served requester is checked last.
  always_comb begin
    logic [IW:0] sum;
    logic [IW:0] wrapped;
    found   = 1'b0;
    pick    = lsp_q;
    sum     = '0;
    wrapped = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum     = {1'b0, lsp_q} + (IW + 1)'(k);
      wrapped = (sum >= NREQ_W) ? (sum - NREQ_W) : sum;
      if (!found && req[wrapped[IW-1:0]]) begin
        found = 1'b1;
        pick  = wrapped[IW-1:0];
      end
    end
  end

  assign wren = (state_q == GRANT) & req[owner_q] & ~fifo_full & rst;
  assign d_in = (state_q == GRANT) ? d_req[int'(owner_q)*WIDTH +: WIDTH] : '0;
  assign gnt  = gnt_q;

  always_comb begin
    ack          = '0;
    ack[owner_q] = wren;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    lsp_d   = lsp_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          state_d     = GRANT;
          owner_d     = pick;
          lsp_d       = pick;
          cnt_d       = '0;
          gnt_d[pick] = 1'b1;
        end
      end
      GRANT: begin
        // A dropped request releases the grant; a full FIFO simply holds everything.
        if (!req[owner_q]) begin
          state_d = IDLE;
          cnt_d   = '0;
          gnt_d   = '0;
        end else if (wren) begin
          if (cnt_q == CNT_MAX) begin
            state_d = IDLE;
            cnt_d   = '0;
            gnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if ((|req) && fifo_full && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      lsp_q   <= LAST_IDX;
      cnt_q   <= '0;
      gnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lsp_q   <= lsp_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus random traffic, all
// checked each cycle against a transaction-level model of the arbitration rules.
module tb_fifo_write_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int BURST = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] d_req = '0;
  logic                  fifo_full = 1'b0;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       gnt;
  logic                  wren;
  logic [WIDTH-1:0]      d_in;
  logic [15:0]           stall_cnt;

  int totalCount = 0;
  int badCount   = 0;

  // model: who owns the FIFO, beats already moved, last-served requester, stall tally
  bit mBusy   = 1'b0;
  int mOwner  = 0;
  int mBeats  = 0;
  int mLsp    = NREQ - 1;
  int mStall  = 0;

  int wrenSeen = 0;
  logic [NREQ-1:0] prevGnt = '0;
  logic [NREQ-1:0] grantLog[$];

  fifo_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .d_req(d_req), .ack(ack), .gnt(gnt),
    .wren(wren), .d_in(d_in), .fifo_full(fifo_full), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got %0h, wanted %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // One clock cycle: drive, compare against model, then advance model at the edge.
  task automatic applyStimulus(input logic r, input logic [NREQ-1:0] rq,
                               input logic f, input logic [NREQ*WIDTH-1:0] d);
    logic [NREQ-1:0]  eGnt;
    logic             eWren;
    logic [NREQ-1:0]  eAck;
    logic [WIDTH-1:0] eDin;
    @(negedge clk);
    rst = r; req = rq; fifo_full = f; d_req = d;
    #1;
    eGnt  = '0;
    eAck  = '0;
    eDin  = '0;
    eWren = 1'b0;
    if (mBusy) begin
      eGnt[mOwner] = 1'b1;
      eDin  = d[mOwner*WIDTH +: WIDTH];
      eWren = rq[mOwner] && !f && r;
      eAck[mOwner] = eWren;
    end
    checkOutput("gnt", 32'(gnt), 32'(eGnt));
    checkOutput("wren", 32'(wren), 32'(eWren));
    checkOutput("ack", 32'(ack), 32'(eAck));
    checkOutput("d_in", 32'(d_in), 32'(eDin));
    checkOutput("stall_cnt", 32'(stall_cnt), 32'(mStall));
    if (wren === 1'b1) wrenSeen++;
    if (gnt !== prevGnt && gnt !== '0) grantLog.push_back(gnt);
    prevGnt = gnt;
    @(posedge clk);
    if (!r) begin
      mBusy = 1'b0; mBeats = 0; mLsp = NREQ - 1; mStall = 0;
    end else begin
      if (rq != '0 && f) mStall = (mStall < 65535) ? mStall + 1 : 65535;
      if (!mBusy) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (!mBusy && rq[(mLsp + k) % NREQ]) begin
            mBusy  = 1'b1;
            mOwner = (mLsp + k) % NREQ;
            mLsp   = mOwner;
            mBeats = 0;
          end
        end
      end else if (!rq[mOwner]) begin
        mBusy = 1'b0;
      end else if (!f) begin
        mBeats++;
        if (mBeats == BURST) mBusy = 1'b0;
      end
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b0, '0, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    logic [NREQ*WIDTH-1:0] dat;
    logic [NREQ-1:0]       rq;
    int                    s0;
    int                    s1;

    doReset();
    checkOutput("reset_gnt", 32'(gnt), 32'h0);
    checkOutput("reset_stall", 32'(stall_cnt), 32'h0);

    dat = 32'h0000_00A5;
    wrenSeen = 0;
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 4'b0001, 1'b0, dat);
    checkOutput("single_burst_beats", 32'(wrenSeen), 32'd9);

    doReset();
    grantLog.delete();
    dat = 32'h4433_2211;
    for (int i = 0; i < 25; i++) applyStimulus(1'b1, 4'b1111, 1'b0, dat);
    checkOutput("rr_grants", 32'(grantLog.size()), 32'd5);
    if (grantLog.size() == 5) begin
      checkOutput("rr_g0", 32'(grantLog[0]), 32'h1);
      checkOutput("rr_g1", 32'(grantLog[1]), 32'h2);
      checkOutput("rr_g2", 32'(grantLog[2]), 32'h4);
      checkOutput("rr_g3", 32'(grantLog[3]), 32'h8);
      checkOutput("rr_g4", 32'(grantLog[4]), 32'h1);
    end

    doReset();
    dat = 32'h00C3_0000;
    applyStimulus(1'b1, 4'b0100, 1'b0, dat);
    applyStimulus(1'b1, 4'b0100, 1'b0, dat);
    s0 = int'(stall_cnt);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'b0100, 1'b1, dat);
    wrenSeen = 0;
    s1 = int'(stall_cnt);
    checkOutput("stall_gnt_held", 32'(gnt), 32'h4);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'b0100, 1'b0, dat);
    checkOutput("stall_delta", 32'(stall_cnt) - 32'(s0), 32'd5);
    checkOutput("stall_during_full", 32'(s1) - 32'(s0), 32'd4);
    checkOutput("stall_tail_beats", 32'(wrenSeen), 32'd3);

    doReset();
    dat = 32'h5566_7788;
    applyStimulus(1'b1, 4'b0010, 1'b0, dat);
    applyStimulus(1'b1, 4'b0111, 1'b0, dat);
    applyStimulus(1'b1, 4'b0111, 1'b0, dat);
    applyStimulus(1'b1, 4'b0101, 1'b0, dat);
    checkOutput("early_release_idle", 32'(gnt), 32'h2);
    applyStimulus(1'b1, 4'b0101, 1'b0, dat);
    checkOutput("early_release_gap", 32'(gnt), 32'h0);
    applyStimulus(1'b1, 4'b0101, 1'b0, dat);
    checkOutput("early_release_next", 32'(gnt), 32'h4);

    doReset();
    dat = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b1111, 1'b0, dat);
    applyStimulus(1'b0, 4'b1111, 1'b0, dat);
    checkOutput("midreset_wren", 32'(wren), 32'h0);
    applyStimulus(1'b1, 4'b1111, 1'b0, dat);
    checkOutput("midreset_gnt", 32'(gnt), 32'h0);
    applyStimulus(1'b1, 4'b1111, 1'b0, dat);
    checkOutput("midreset_regrant", 32'(gnt), 32'h1);

    doReset();
    rq = 4'b0000;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = NREQ'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 99) != 0), rq, ($urandom_range(0, 3) == 0),
                    NREQ*WIDTH'($urandom));
    end

    doReset();
    wrenSeen = 0;
    for (int i = 0; i < 70000; i++) applyStimulus(1'b1, 4'b0001, 1'b1, 32'h0000_0011);
    checkOutput("sat_value", 32'(stall_cnt), 32'hFFFF);
    checkOutput("sat_no_wren", 32'(wrenSeen), 32'd0);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
